// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csc258_adder_pkg
// Shared definitions for the nibble-serial adder controller:
//   NIBBLE_W       - width of one adder step (4 bits)
//   adder_state_t  - controller FSM encoding
//   cnt_width()    - width of the step counter for a given NIBBLES
// ---------------------------------------------------------------------------
package csc258_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  // clog2(nibbles), never narrower than one bit so NIBBLES=1 still has a counter
  function automatic int cnt_width(input int nibbles);
    if (nibbles <= 1) begin
      return 1;
    end else begin
      return $clog2(nibbles);
    end
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// ---------------------------------------------------------------------------
// nibble_adder
// Purely combinational 4-bit ripple-carry adder built from full-adder cells.
// Ports:
//   x[3:0], y[3:0]  addends
//   ci              carry in
//   s[3:0]          sum
//   co              carry out of bit 3
// ---------------------------------------------------------------------------
module nibble_adder
  import csc258_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  // One full-adder bit cell: returns {carry, sum}
  function automatic logic [1:0] full_add(input logic fx, input logic fy, input logic fc);
    return {(fx & fy) | (fx & fc) | (fy & fc), fx ^ fy ^ fc};
  endfunction

  logic [NIBBLE_W:0] c_s;
  logic [1:0]        cell_s;

  // Ripple the carry through the four bit cells
  always_comb begin
    c_s    = {(NIBBLE_W+1){1'b0}};
    s      = {NIBBLE_W{1'b0}};
    cell_s = 2'b00;
    c_s[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      cell_s     = full_add(x[i], y[i], c_s[i]);
      s[i]       = cell_s[0];
      c_s[i+1]   = cell_s[1];
    end
    co = c_s[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Adds two W = 4*NIBBLES bit operands with one shared 4-bit adder, one nibble
// per clock, least significant nibble first. Start/ready/done handshake.
// Ports:
//   clock, resetn          clock, synchronous active-low reset
//   start                  launch request, taken only while ready
//   a, b, c_in             operands and initial carry, sampled on accept
//   ready / busy / done    IDLE / RUN / one-cycle DONE, decoded from state
//   sum, c_out, overflow   registered result, updated only on completion
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
  import csc258_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [4*NIBBLES-1:0]    a,
  input  logic [4*NIBBLES-1:0]    b,
  input  logic                    c_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [4*NIBBLES-1:0]    sum,
  output logic                    c_out,
  output logic                    overflow
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NIBBLES - 1);

  adder_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-1:0]   work_q, work_d;
  logic           carry_q, carry_d;
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           c_out_q, c_out_d;
  logic           ovf_q, ovf_d;

  logic [NIBBLE_W-1:0]   nib_s;
  logic                  nib_co;
  logic [W+NIBBLE_W-1:0] work_cat_s;
  logic [W-1:0]          work_next_s;

  nibble_adder u_nibble_adder (
    .x  (a_sh_q[NIBBLE_W-1:0]),
    .y  (b_sh_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  // New nibble enters at the top; concatenation keeps this legal when W == 4
  assign work_cat_s  = {nib_s, work_q};
  assign work_next_s = work_cat_s[W+NIBBLE_W-1:NIBBLE_W];

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    work_d  = work_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = {CNT_W{1'b0}};
          a_msb_d = a[W-1];
          b_msb_d = b[W-1];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        work_d  = work_next_s;
        carry_d = nib_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          sum_d   = work_next_s;
          c_out_d = nib_co;
          ovf_d   = (a_msb_q == b_msb_q) && (work_next_s[W-1] != a_msb_q);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_sh_q  <= {W{1'b0}};
      b_sh_q  <= {W{1'b0}};
      work_q  <= {W{1'b0}};
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= {W{1'b0}};
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Vector table plus hand-written corner sequences for the nibble-serial adder.
// Expected results are pushed to a scoreboard when an operation is launched
// and popped by a monitor when done is seen. A second instance uses NIBBLES=1.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

  localparam int NIB = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        ready, busy, done;
  logic [15:0] sum;
  logic        c_out, overflow;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        cin1;
  logic        ready1, busy1, done1;
  logic [3:0]  sum1;
  logic        c_out1, overflow1;

  int n_tests = 0;
  int n_fails = 0;
  int done_cnt = 0;
  logic [15:0] last_sum = 16'h0000;
  exp_t sb[$];
  vec_t vecs[7];

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clock(clk), .resetn(resetn), .start(start), .a(a), .b(b), .c_in(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .c_out(c_out),
    .overflow(overflow)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clock(clk), .resetn(resetn), .start(start1), .a(a1), .b(b1), .c_in(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1),
    .overflow(overflow1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fails++;
        $display("FAIL unexpected_done: done seen with empty scoreboard");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_sum", {16'h0, sum}, {16'h0, e.s});
        chk("sb_c_out", {31'h0, c_out}, {31'h0, e.co});
        chk("sb_overflow", {31'h0, overflow}, {31'h0, e.ov});
      end
    end
  end

  // Launch one operation and check handshake timing; optionally disturb inputs mid-run
  task automatic run_op(input vec_t v, input bit disturb);
    bit   seen;
    int   dc0;
    exp_t e;
    dc0 = done_cnt;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    e.s = v.s; e.co = v.co; e.ov = v.ov;
    sb.push_back(e);
    @(negedge clk);          // cycle T+1
    start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= NIB + 3 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (disturb && k == 1) begin
        start = 1'b1; a = 16'h1111;
      end
      if (disturb && k == 2) begin
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      end
      if (k <= NIB) begin
        chk("busy_in_run", {31'h0, busy}, 32'h1);
        chk("no_done_in_run", {31'h0, done}, 32'h0);
        chk("sum_held", {16'h0, sum}, {16'h0, last_sum});
      end else if (done === 1'b1) begin
        chk("done_latency", k, NIB + 1);
        chk("busy_low_in_done", {31'h0, busy}, 32'h0);
        seen = 1'b1;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fails++;
      $display("FAIL done_timeout: no done within %0d cycles", NIB + 3);
    end
    @(negedge clk);          // IDLE cycle; drop start before its edge
    start = 1'b0;
    chk("ready_after_done", {31'h0, ready}, 32'h1);
    repeat (2) @(negedge clk);
    chk("one_done", done_cnt - dc0, 1);
    last_sum = v.s;
  endtask

  initial begin
    // a, b, cin, sum, c_out, overflow
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[6] = '{16'h9ABC, 16'h6544, 1'b1, 16'h0001, 1'b1, 1'b0};

    resetn = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_sum", {16'h0, sum}, 32'h0);
    chk("rst_c_out", {31'h0, c_out}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], 1'b0);
    end

    // Extra start during RUN/DONE and operands changed mid-run
    run_op('{16'h2468, 16'h1357, 1'b0, 16'h37BF, 1'b0, 1'b0}, 1'b1);

    // Reset in the second RUN cycle aborts the operation
    begin
      int dc0;
      dc0 = done_cnt;
      @(negedge clk);
      a = 16'h1111; b = 16'h1111; cin = 1'b0; start = 1'b1;
      @(negedge clk);        // T+1
      start = 1'b0;
      @(negedge clk);        // T+2, second RUN cycle
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("abort_ready", {31'h0, ready}, 32'h1);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_done", {31'h0, done}, 32'h0);
      chk("abort_sum", {16'h0, sum}, 32'h0);
      chk("abort_c_out", {31'h0, c_out}, 32'h0);
      chk("abort_overflow", {31'h0, overflow}, 32'h0);
      repeat (6) @(negedge clk);
      chk("abort_no_done", done_cnt - dc0, 0);
      last_sum = 16'h0000;
    end
    run_op('{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0}, 1'b0);

    // NIBBLES=1 instance: done two cycles after accept
    @(negedge clk);
    a1 = 4'hF; b1 = 4'h0; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_busy", {31'h0, busy1}, 32'h1);
    chk("n1_sum_held", {28'h0, sum1}, 32'h0);
    @(negedge clk);
    chk("n1_done", {31'h0, done1}, 32'h1);
    chk("n1_sum", {28'h0, sum1}, 32'h0);
    chk("n1_c_out", {31'h0, c_out1}, 32'h1);
    chk("n1_overflow", {31'h0, overflow1}, 32'h0);
    @(negedge clk);
    chk("n1_ready", {31'h0, ready1}, 32'h1);
    chk("n1_done_cleared", {31'h0, done1}, 32'h0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
